// File: rtl/torus_inject_sched.sv
// torus_inject_sched: per-PE injection scheduler in front of a torus router
// injection port. A token bucket meters packets (one token per MAX_RATE
// cycles, burst up to MAX_TOKEN), a single output register holds each packet
// until the router takes it, and a run of PKT_N packets ends in DONE.
// Optional build macro INJECT_STALL_STAT_EN adds a saturating count of
// cycles where the router back-pressures an offered packet.
module torus_inject_sched #(
    parameter int D_W       = 16,
    parameter int MAX_RATE  = 5,
    parameter int MAX_TOKEN = 2,
    parameter int PKT_N     = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         src_valid,
    input  logic [D_W-1:0]               src_data,
    output logic                         src_ready,
    output logic                         pe_valid,
    output logic [D_W-1:0]               pe_data,
    input  logic                         pe_ready,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(PKT_N+1)-1:0]   sent_cnt,
    output logic [31:0]                  stall_cnt
);
    localparam int CW = $clog2(PKT_N + 1);
    localparam int TW = $clog2(MAX_TOKEN + 1);
    localparam int RW = (MAX_RATE > 1) ? $clog2(MAX_RATE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state;
    logic [TW-1:0] tokens;
    logic [RW-1:0] rate_cnt;
    logic [CW-1:0] issued;

    logic active, go, refill, issue, hs;

    // Decode of the current cycle's events; src_ready is the issue strobe.
    always_comb begin
        active    = (state == S_RUN) || (state == S_DRAIN);
        go        = start && ((state == S_IDLE) || (state == S_DONE));
        refill    = active && (rate_cnt == RW'(MAX_RATE - 1));
        issue     = (state == S_RUN) && (tokens != '0) && (issued < CW'(PKT_N))
                    && src_valid && (!pe_valid || pe_ready);
        hs        = pe_valid && pe_ready;
        src_ready = issue;
    end

    // Run-control FSM; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                end
                S_RUN: if (issue && (issued == CW'(PKT_N - 1))) state <= S_DRAIN;
                // Only one packet can be outstanding, so any handshake here is the last.
                S_DRAIN: if (hs) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_DONE: if (start) begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Token bucket: refill on rate wrap, spend on issue; both at once is a wash.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tokens   <= '0;
            rate_cnt <= '0;
        end else if (go) begin
            tokens   <= TW'(MAX_TOKEN);
            rate_cnt <= '0;
        end else begin
            if (active) rate_cnt <= refill ? '0 : rate_cnt + 1'b1;
            case ({issue, refill})
                2'b10:   tokens <= tokens - 1'b1;
                2'b01:   if (tokens < TW'(MAX_TOKEN)) tokens <= tokens + 1'b1;
                default: tokens <= tokens;
            endcase
        end
    end

    // Output register: loads on issue, clears on handshake, holds while blocked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_valid <= 1'b0;
            pe_data  <= '0;
        end else if (issue) begin
            pe_valid <= 1'b1;
            pe_data  <= src_data;
        end else if (hs) begin
            pe_valid <= 1'b0;
        end
    end

    // Issued and accepted packet counts for the current run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued   <= '0;
            sent_cnt <= '0;
        end else if (go) begin
            issued   <= '0;
            sent_cnt <= '0;
        end else begin
            if (issue) issued   <= issued + 1'b1;
            if (hs)    sent_cnt <= sent_cnt + 1'b1;
        end
    end

`ifdef INJECT_STALL_STAT_EN
    logic [31:0] stall_r;

    // Saturating count of back-pressured cycles while a run is active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_r <= '0;
        else if (go)
            stall_r <= '0;
        else if (active && pe_valid && !pe_ready && (stall_r != 32'hFFFF_FFFF))
            stall_r <= stall_r + 1'b1;
    end

    assign stall_cnt = stall_r;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_torus_inject_sched.sv
// Directed bench for torus_inject_sched: default-parameter instance for the
// burst/stall/idle-source/reset/ignored-start cases, and a rate-1 bucket-1
// instance for the full-throughput case.
module tb_torus_inject_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, src_valid, pe_ready;
    logic [15:0] src_data;
    logic        src_ready, pe_valid, busy, done;
    logic [15:0] pe_data;
    logic [4:0]  sent_cnt;
    logic [31:0] stall_cnt;

    logic        start2, src_valid2, pe_ready2;
    logic [15:0] src_data2;
    logic        src_ready2, pe_valid2, busy2, done2;
    logic [15:0] pe_data2;
    logic [2:0]  sent_cnt2;
    logic [31:0] stall_cnt2;

    torus_inject_sched dut (
        .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
        .busy(busy), .done(done), .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
    );

    torus_inject_sched #(.D_W(16), .MAX_RATE(1), .MAX_TOKEN(1), .PKT_N(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .src_valid(src_valid2), .src_data(src_data2),
        .src_ready(src_ready2), .pe_valid(pe_valid2), .pe_data(pe_data2), .pe_ready(pe_ready2),
        .busy(busy2), .done(done2), .sent_cnt(sent_cnt2), .stall_cnt(stall_cnt2)
    );

`ifdef INJECT_STALL_STAT_EN
    localparam int STALL_EXP = 8;
`else
    localparam int STALL_EXP = 0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int          hs_cyc[$];
    logic [15:0] hs_dat[$];
    int          hs2_cyc[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Record router handshakes with the cycle they occur in.
    always @(negedge clk) begin
        if (rst && pe_valid && pe_ready) begin
            hs_cyc.push_back(cyc);
            hs_dat.push_back(pe_data);
        end
        if (rst && pe_valid2 && pe_ready2) hs2_cyc.push_back(cyc);
    end

    task automatic tick();
        logic take, take2;
        #1;
        take  = src_valid && src_ready;
        take2 = src_valid2 && src_ready2;
        @(posedge clk);
        #1;
        cyc++;
        if (take)  src_data  = src_data + 16'd1;
        if (take2) src_data2 = src_data2 + 16'd1;
    endtask

    // One 20-packet run; pe_ready low on s+2..s+stall_hi, src_valid low on s+1..s+src_off.
    task automatic run_seq(input string nm, input int stall_hi, input int src_off,
                           input bit poke, input int exp_q[$]);
        int s, done_at, n;
        hs_cyc.delete();
        hs_dat.delete();
        src_data  = 16'hA000;
        s         = cyc;
        start     = 1'b1;
        pe_ready  = 1'b1;
        src_valid = (src_off == 0);
        tick();
        start   = 1'b0;
        done_at = -1;
        while (done_at < 0 && cyc < s + 300) begin
            pe_ready  = !(stall_hi > 0 && cyc >= s + 2 && cyc <= s + stall_hi);
            src_valid = (cyc > s + src_off);
            start     = poke && (cyc == s + 20);
            #1;
            if (!src_valid) chk({nm, "_srcrdy_idle"}, src_ready, 0);
            if (!pe_ready) begin
                chk({nm, "_stall_vld"}, pe_valid, 1);
                chk({nm, "_stall_hold"}, pe_data, 16'hA000);
            end
            if (poke && cyc == s + 21) begin
                chk({nm, "_ign_start_sent"}, sent_cnt, 5);
                chk({nm, "_ign_start_busy"}, busy, 1);
            end
            if (done) done_at = cyc - s;
            tick();
        end
        start = 1'b0;
        chk({nm, "_done_cyc"}, done_at, exp_q[exp_q.size()-1] + 1);
        chk({nm, "_hs_count"}, hs_cyc.size(), 20);
        n = (hs_cyc.size() < 20) ? hs_cyc.size() : 20;
        for (int i = 0; i < n; i++) begin
            chk({nm, "_hs_cyc"}, hs_cyc[i] - s, exp_q[i]);
            chk({nm, "_hs_dat"}, hs_dat[i], 16'hA000 + i);
        end
        chk({nm, "_sent"}, sent_cnt, 20);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_stall_cnt"}, stall_cnt, (stall_hi > 0) ? STALL_EXP : 0);
    endtask

    int exp_base[$], exp_stall[$], exp_idle[$];

    initial begin
        int s, d2;
        rst = 1'b0; start = 1'b0; src_valid = 1'b1; src_data = 16'hA000; pe_ready = 1'b1;
        start2 = 1'b0; src_valid2 = 1'b1; src_data2 = 16'h0; pe_ready2 = 1'b1;

        // Hand-derived handshake cycles relative to the start cycle.
        exp_base = '{2, 3};
        for (int k = 0; k < 18; k++) exp_base.push_back(7 + 5 * k);
        exp_stall = '{10, 11, 12, 13};
        for (int k = 0; k < 16; k++) exp_stall.push_back(17 + 5 * k);
        exp_idle = '{32, 33};
        for (int k = 0; k < 18; k++) exp_idle.push_back(37 + 5 * k);

        tick(); tick();
        chk("rst_pe_valid", pe_valid, 0);
        chk("rst_pe_data", pe_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_stall", stall_cnt, 0);
        rst = 1'b1;
        tick();
        #1;
        chk("idle_srcrdy", src_ready, 0);
        chk("idle_busy", busy, 0);

        run_seq("base", 0, 0, 1'b1, exp_base);
        chk("base_done_hold", done, 1);
        run_seq("stall", 9, 0, 1'b0, exp_stall);
        run_seq("srcidle", 0, 30, 1'b0, exp_idle);

        // Rate-1, bucket-1 instance: issue every cycle, 4 back-to-back handshakes.
        hs2_cyc.delete();
        s = cyc;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        d2 = -1;
        while (d2 < 0 && cyc < s + 50) begin
            #1;
            if (cyc <= s + 4) chk("r1_srcrdy", src_ready2, 1);
            if (done2) d2 = cyc - s;
            tick();
        end
        chk("r1_done_cyc", d2, 6);
        chk("r1_hs_count", hs2_cyc.size(), 4);
        for (int i = 0; i < 4 && i < hs2_cyc.size(); i++) chk("r1_hs_cyc", hs2_cyc[i] - s, 2 + i);
        chk("r1_sent", sent_cnt2, 4);

        // Reset while a packet is held against a blocked router.
        src_data = 16'hA000;
        src_valid = 1'b1;
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        pe_ready = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("mid_pre_vld", pe_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", pe_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sent", sent_cnt, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_srcrdy", src_ready, 0);
        tick(); tick();
        rst = 1'b1;
        pe_ready = 1'b1;
        tick();
        run_seq("post_rst", 0, 0, 1'b0, exp_base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
